// File: rtl/cross_decode.sv
// Thermometer crossbar-control decoder/checker; 2-stage valid/ready, 2-cycle latency, stalls upstream when S2 is held.
// Define CROSS_DECODE_COLLISION_EN to build per-output collision detection (otherwise collision is tied to 0).
module cross_decode #(
  parameter int number_ports = 2,
  localparam int N  = number_ports,
  localparam int DW = $clog2(number_ports)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*N-1:0]    ctr_in,
  input  logic              ctr_valid,
  output logic              ctr_ready,
  output logic [DW*N-1:0]   destinations,
  output logic [N-1:0]      malformed,
  output logic [N-1:0]      collision,
  output logic              dest_valid,
  input  logic              dest_ready,
  output logic [7:0]        err_count
);

  localparam logic [DW:0] ONE = 1;

  logic             s1_valid;
  logic [N*N-1:0]   s1_ctr;
  logic             s2_load;
  logic             in_xfer;
  logic [DW*N-1:0]  dec_dest;
  logic [N-1:0]     dec_mal;

  assign s2_load   = s1_valid && (!dest_valid || dest_ready);
  assign ctr_ready = !s1_valid || s2_load;
  assign in_xfer   = ctr_valid && ctr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_ctr   <= '0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      s1_ctr   <= ctr_in;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // A legal row has exactly d zeros at the bottom, so the zero count is the destination.
  always_comb begin
    logic [N-1:0] row;
    logic [DW:0]  zeros;
    logic         bad;
    dec_dest = '0;
    dec_mal  = '0;
    row      = '0;
    zeros    = '0;
    bad      = 1'b0;
    for (int i = 0; i < N; i++) begin
      row   = s1_ctr[i*N +: N];
      zeros = '0;
      bad   = !row[N-1];
      for (int j = 0; j < N; j++) begin
        if (!row[j]) zeros = zeros + ONE;
      end
      for (int j = 0; j < N-1; j++) begin
        if (row[j] && !row[j+1]) bad = 1'b1;
      end
      dec_mal[i]            = bad;
      dec_dest[i*DW +: DW]  = bad ? '0 : zeros[DW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dest_valid   <= 1'b0;
      destinations <= '0;
      malformed    <= '0;
      err_count    <= '0;
    end else if (s2_load) begin
      dest_valid   <= 1'b1;
      destinations <= dec_dest;
      malformed    <= dec_mal;
      if (|dec_mal && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end else if (dest_ready) begin
      dest_valid   <= 1'b0;
    end
  end

`ifdef CROSS_DECODE_COLLISION_EN
  logic [N-1:0] dec_coll;

  // Second well-formed claim on an output marks it; malformed rows are excluded.
  always_comb begin
    logic [N-1:0]  seen;
    logic [DW-1:0] d;
    dec_coll = '0;
    seen     = '0;
    d        = '0;
    for (int i = 0; i < N; i++) begin
      if (!dec_mal[i]) begin
        d = dec_dest[i*DW +: DW];
        if (seen[d]) dec_coll[d] = 1'b1;
        seen[d] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          collision <= '0;
    else if (s2_load) collision <= dec_coll;
  end
`else
  assign collision = '0;
`endif

endmodule

// File: doc/cross_decode.md
# cross_decode

Inverse of the crossbar control generator. Accepts a registered stream of thermometer-coded crossbar control matrices, decodes each row back into a per-port destination index, and flags malformed rows and output collisions. It sits on the crossbar control path as the checker/monitor end, feeding destination indices to arbitration bookkeeping and error logging. It is a two-stage, valid/ready pipeline with backpressure.

## Interface
- number_ports, 2, crossbar port count N (≥2); DW = $clog2(N) is the destination index width
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- ctr_in  input  N*N  control matrix; row i = bits [i*N +: N]; bit j of row i = 1 iff j ≥ destination of port i
- ctr_valid  input  1  ctr_in holds a word
- ctr_ready  output  1  block accepts ctr_in this cycle
- destinations  output  DW*N  port i destination at [i*DW +: DW]
- malformed  output  N  bit i = row i not a legal thermometer row
- collision  output  N  bit k = two or more well-formed rows decode to destination k
- dest_valid  output  1  outputs hold a decoded word
- dest_ready  input  1  downstream consumes the word
- err_count  output  8  saturating count of accepted words with any malformed bit set

## Operation
- Legal row for destination d: bits [N-1:d] = 1, bits [d-1:0] = 0, with d < N. Decoded d = N − popcount(row).
- Malformed row: bit N-1 = 0, or any j with row[j]=1 and row[j+1]=0. The port's destination is forced to 0 and malformed[i] = 1.
- Stage 1 (S1) registers ctr_in on the transfer `ctr_valid && ctr_ready`. It then computes destinations and malformed combinationally from the S1 register.
- Stage 2 (S2) registers destinations, malformed and collision. S2 outputs drive the ports directly.
- Collision: for each output k, count the well-formed rows whose destination is k. Set collision[k] when the count is ≥2. Malformed rows never contribute.
- Advance rules:
  - s2_load = s1_valid && (!dest_valid || dest_ready)
  - ctr_ready = !s1_valid || s2_load
- S1 and S2 each hold at most one word. No word is dropped or duplicated.
- err_count increments by 1 at the S2 load of a word with |malformed = 1. It saturates at 8'hFF.
- State per stage: EMPTY / FULL (the valid bit).
  - S1 goes EMPTY→FULL on an input transfer.
  - S1 goes FULL→EMPTY on s2_load without a simultaneous input transfer.
  - S1 stays FULL when an input transfer and s2_load happen in the same cycle.
- Simultaneous consume and load at S2: the new word replaces the old in the same edge, and dest_valid stays 1.

## Timing
- Latency: a word accepted at edge n appears on the outputs with dest_valid = 1 after edge n+1, provided S2 was free.
- Throughput: one word per cycle while dest_ready = 1.
- ctr_ready is combinational from dest_valid, dest_ready and s1_valid. There is no combinational path from ctr_in to any output.
- Outputs stay stable while dest_valid && !dest_ready.
- Reset, asynchronous at any time, including mid-transfer:
  - dest_valid = 0, s1_valid = 0
  - destinations = 0, malformed = 0, collision = 0, err_count = 0
  - in-flight words are discarded
  - ctr_ready = 1 in the first cycle after deassertion

## Configuration
- CROSS_DECODE_COLLISION_EN
  - Defined: collision detection is built as described.
  - Undefined: no collision logic is synthesized. The collision port is tied to 0 and all other behaviour is unchanged.

## Test plan
- Reset defaults (N=4): assert rst mid-stream -> dest_valid=0, err_count=0, all outputs 0, ctr_ready=1 after release.
- Legal decode (N=4): ctr_in=16'hFE8C, dest_ready=1 -> two edges later destinations=8'h1E, malformed=0, collision=0, dest_valid=1.
- Malformed row (N=4): ctr_in=16'hFE8A -> destinations=8'h1C, malformed=4'b0001, err_count=1.
  - Repeat 300 times -> err_count=8'hFF.
- Collision (N=4): ctr_in=16'hFF8C -> destinations=8'h0E, collision=4'b0001.
  - Without CROSS_DECODE_COLLISION_EN -> collision=0.
- Backpressure: dest_ready=0, ctr_valid=1 for 3 words A,B,C -> A and B are accepted and ctr_ready=0 thereafter.
  - A is held stable at the outputs.
  - Raise dest_ready -> A, B, C emerge in order on consecutive cycles.
  - No loss or duplication.
- Streaming: 100 random legal words with random dest_ready -> output sequence equals a reference-model decode of the input sequence, one word per cycle when dest_ready=1.
